// File: rtl/wb_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : wb_port_arbiter_if
// Description : Bundles the signals between the write-back stage, the late
//               result source, the issue logic and the register-file write
//               port. The interface covers the three request paths and the
//               arbitrated write port.
//               slave  : arbiter view. Receives i_* and drives or_*.
//               master : environment view. Drives i_* and receives or_*.
//               Signals:
//                 i_pipe_write/_rd_addr/_rd_data : pipeline write-back request
//                 i_lsu_valid/_rd_addr/_rd_data  : late result, valid/ready handshake
//                 or_lsu_ready                   : late-result queue not full
//                 i_issue_valid/_rd              : long-latency issue
//                 or_rd_write/_addr/_data        : register-file write port
//                 or_stall                       : pipeline must hold its request
//                 or_busy_mask                   : outstanding long-latency destinations
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef XADDR
`define XADDR 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface wb_port_arbiter_if;
    logic                i_pipe_write;
    logic [`XADDR-1:0]   i_pipe_rd_addr;
    logic [`XLEN-1:0]    i_pipe_rd_data;
    logic                i_lsu_valid;
    logic [`XADDR-1:0]   i_lsu_rd_addr;
    logic [`XLEN-1:0]    i_lsu_rd_data;
    logic                or_lsu_ready;
    logic                i_issue_valid;
    logic [`XADDR-1:0]   i_issue_rd;
    logic                or_rd_write;
    logic [`XADDR-1:0]   or_rd_addr;
    logic [`XLEN-1:0]    or_rd_data;
    logic                or_stall;
    logic [31:0]         or_busy_mask;

    modport slave (
        input  i_pipe_write, i_pipe_rd_addr, i_pipe_rd_data,
        input  i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
        output or_lsu_ready,
        input  i_issue_valid, i_issue_rd,
        output or_rd_write, or_rd_addr, or_rd_data,
        output or_stall, or_busy_mask
    );

    modport master (
        output i_pipe_write, i_pipe_rd_addr, i_pipe_rd_data,
        output i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
        input  or_lsu_ready,
        output i_issue_valid, i_issue_rd,
        input  or_rd_write, or_rd_addr, or_rd_data,
        input  or_stall, or_busy_mask
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order pipeline write-back and a queue of late
//               (long-latency) results. The pipeline has priority, but a
//               starvation counter forces the queue head through after
//               STARVE_LIMIT denied cycles. The block also keeps a busy-register
//               scoreboard for the hazard unit.
// Ports       : i_clk   - clock, rising edge
//               i_rst_n - asynchronous active-low reset
//               bus     - wb_port_arbiter_if.slave. Carries the pipeline, LSU
//                         and issue requests, the write port, the stall and
//                         the busy mask.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef XADDR
`define XADDR 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

module wb_port_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input wire logic          i_clk,
    input wire logic          i_rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int unsigned c_IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned c_PTR_W = c_IDX_W + 1;
    localparam logic [3:0]  c_LIMIT = 4'(STARVE_LIMIT);

    // Queue storage (data path only, no reset needed)
    logic [`XADDR-1:0]  fifo_addr [FIFO_DEPTH];
    logic [`XLEN-1:0]   fifo_data [FIFO_DEPTH];

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               rd_write_q, rd_write_d;
    logic [`XADDR-1:0]  rd_addr_q, rd_addr_d;
    logic [`XLEN-1:0]   rd_data_q, rd_data_d;
    logic [31:0]        busy_mask_q, busy_mask_d;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_forced;
    logic               w_grant_q;
    logic               w_grant_p;
    logic [`XADDR-1:0]  w_head_addr;
    logic [`XLEN-1:0]   w_head_data;

    // Extended pointers: equal means empty; equal index with differing MSB means full
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_IDX_W-1:0] == rd_ptr_q[c_IDX_W-1:0]) &&
                     (wr_ptr_q[c_IDX_W] != rd_ptr_q[c_IDX_W]);

    assign w_head_addr = fifo_addr[rd_ptr_q[c_IDX_W-1:0]];
    assign w_head_data = fifo_data[rd_ptr_q[c_IDX_W-1:0]];

    // Readiness uses the registered full flag only, so a same-cycle pop never
    // opens a slot for a push.
    assign w_push    = bus.i_lsu_valid && !w_full;
    assign w_forced  = !w_empty && bus.i_pipe_write && (wait_cnt_q == c_LIMIT);
    assign w_grant_q = !w_empty && (!bus.i_pipe_write || w_forced);
    assign w_grant_p = bus.i_pipe_write && !w_grant_q;

    assign bus.or_lsu_ready = !w_full;
    assign bus.or_stall     = w_forced;
    assign bus.or_rd_write  = rd_write_q;
    assign bus.or_rd_addr   = rd_addr_q;
    assign bus.or_rd_data   = rd_data_q;
    assign bus.or_busy_mask = busy_mask_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        rd_write_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        busy_mask_d = busy_mask_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_grant_q) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Starvation counter: counts denied cycles of a present head
        if (w_empty || w_grant_q) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < c_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        // Writes to x0 are consumed but never reach the register file
        if (w_grant_q) begin
            rd_addr_d  = w_head_addr;
            rd_data_d  = w_head_data;
            rd_write_d = (w_head_addr != '0);
        end else if (w_grant_p) begin
            rd_addr_d  = bus.i_pipe_rd_addr;
            rd_data_d  = bus.i_pipe_rd_data;
            rd_write_d = (bus.i_pipe_rd_addr != '0);
        end

        // Clear first, then set, so a same-cycle issue keeps the register busy
        if (w_grant_q) begin
            busy_mask_d[w_head_addr] = 1'b0;
        end
        if (bus.i_issue_valid && (bus.i_issue_rd != '0)) begin
            busy_mask_d[bus.i_issue_rd] = 1'b1;
        end
        busy_mask_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_cnt_q  <= 4'd0;
            rd_write_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            busy_mask_q <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_write_q  <= rd_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            busy_mask_q <= busy_mask_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            fifo_addr[wr_ptr_q[c_IDX_W-1:0]] <= bus.i_lsu_rd_addr;
            fifo_data[wr_ptr_q[c_IDX_W-1:0]] <= bus.i_lsu_rd_data;
        end
    end
endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline write-back path and a long-latency result source, such as LSU load returns or CSR read data. Late results queue in a small FIFO. The pipeline write has priority, but a starvation limit guarantees queued results drain. A busy-register scoreboard tracks outstanding long-latency destinations for the hazard unit. The block sits between the write-back stage outputs and the register file write port.

## Interface
Parameters:
- FIFO_DEPTH, 2: late-result queue entries; power of two, ≥2.
- STARVE_LIMIT, 4: cycles a non-empty queue head may be denied before it is forcibly granted; range 1..15.

Ports:
- i_clk  in  1  CPU clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_pipe_write  in  1  pipeline write-back request.
- i_pipe_rd_addr  in  `XADDR  pipeline destination register.
- i_pipe_rd_data  in  `XLEN  pipeline write data.
- i_lsu_valid  in  1  late result valid.
- i_lsu_rd_addr  in  `XADDR  late result destination.
- i_lsu_rd_data  in  `XLEN  late result data.
- or_lsu_ready  out  1  queue can accept; transfer happens when i_lsu_valid and or_lsu_ready are both high.
- i_issue_valid  in  1  long-latency op issued this cycle.
- i_issue_rd  in  `XADDR  its destination register.
- or_rd_write  out  1  register-file write enable (registered).
- or_rd_addr  out  `XADDR  register-file write address (registered).
- or_rd_data  out  `XLEN  register-file write data (registered).
- or_stall  out  1  pipeline must hold its write-back request this cycle (combinational).
- or_busy_mask  out  32  bit n=1: register xn has an outstanding long-latency write (registered).

## Operation
- Queue: FIFO of {rd_addr, rd_data}, FIFO_DEPTH entries, with read/write pointers one bit wider than the index.
  - or_lsu_ready = !full. A pop does not free space for a push in the same cycle.
  - A push becomes visible at the head the cycle after it is accepted. There is no bypass.
- wait_cnt: 4 bits, reset 0.
  - Increments, saturating at STARVE_LIMIT, in each cycle the queue is non-empty and the head is not granted.
  - Cleared on a queue grant or while the queue is empty.
- Grant selection, evaluated each cycle from current state:
  - Queue empty: grant the pipeline (if i_pipe_write).
  - Queue non-empty and !i_pipe_write: grant the queue head.
  - Queue non-empty and i_pipe_write and wait_cnt < STARVE_LIMIT: grant the pipeline.
  - Queue non-empty and i_pipe_write and wait_cnt == STARVE_LIMIT: grant the queue head and assert or_stall. The pipeline holds its request unchanged into the next cycle.
- or_stall is high only in the forced-grant case.
- Commit: at the clock edge, or_rd_* take the granted {addr, data} and or_rd_write=1. With no grant, or_rd_write=0 and addr/data hold their previous values.
- x0: any granted write with addr 0 drives or_rd_write=0. The queue still pops and the pipeline request is still consumed.
- Scoreboard:
  - On i_issue_valid with i_issue_rd≠0, set that busy bit.
  - On a queue-head grant, clear the bit of the head's rd.
  - Same register set and cleared in one cycle: set wins.
  - Issue to an already-busy register leaves it busy.
  - Bit 0 is always 0.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - or_rd_write=0, or_rd_addr=0, or_rd_data=0.
  - or_busy_mask=0, queue empty, wait_cnt=0.
  - Therefore or_lsu_ready=1 and or_stall=0 while in reset.
- Reset asserted mid-operation discards all queued results and busy bits immediately.
- Pipeline latency: request in cycle N → or_rd_write high in cycle N+1.
- Late-result latency, minimum: accepted in cycle N → head in N+1 → or_rd_write high in N+2 (if granted).
- Worst-case head wait under continuous i_pipe_write: STARVE_LIMIT denied cycles, then forced grant on the next cycle.
- A push and a pop of a non-full queue in the same cycle: count unchanged, pointers both advance.
- Pointer wrap-around is by natural overflow of the extended pointers.
- full = index bits equal and MSBs differ; empty = pointers equal.

## Test plan
- Reset:
  - Assert i_rst_n=0 mid-traffic → all outputs 0 immediately, or_lsu_ready=1.
  - After release, an earlier-queued result never appears.
- Pipeline only:
  - i_pipe_write with rd=5, data=0xDEADBEEF in cycle N → cycle N+1 shows or_rd_write=1, or_rd_addr=5, or_rd_data=0xDEADBEEF, or_stall=0.
- Late result on idle pipeline:
  - Issue rd=7 → or_busy_mask[7]=1.
  - LSU pushes rd=7, data=0x12345678 in cycle N → write appears in cycle N+2; busy bit 7 clears in the same cycle.
- Starvation (STARVE_LIMIT=4):
  - Continuous pipeline writes plus one queued result → or_stall high exactly once, on the 5th cycle the head is present.
  - Queued data written next edge; the held pipeline data written the following edge with no loss.
- Full queue:
  - Push 2 with i_pipe_write held high → or_lsu_ready=0; a 3rd valid is not accepted.
  - Ready returns 1 the cycle after the first pop.
  - Data order preserved across pointer wrap (≥5 pushes).
- x0 and scoreboard collision:
  - Queued result to rd=0 → or_rd_write=0, queue pops.
  - Issue rd=9 in the same cycle rd=9's queued result commits → busy bit 9 remains 1.
